t_ff_counter: RTL



---
 rtl/t_ff_pkg.sv | 77 +++++++
 rtl/t_ff_cell.sv | 34 +++
 rtl/t_ff_counter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/t_ff_pkg.sv
// -----------------------------------------------------------------------------
// t_ff_pkg
// Shared definitions for the T flip-flop counter family.
//   - DIR_UP / DIR_DOWN : encodings of the 'up' direction input.
//   - word_t            : widest supported counter word (32 bits). Callers
//                         zero-extend their WIDTH-bit values into it and keep
//                         the low WIDTH bits of the result.
//   - clamp_val()       : min(d, max_val), the value a parallel load settles to.
//   - toggle_vec()      : T vector for one enabled count step from Q, direction
//                         and modulus, including the boundary (wrap or hold).
// -----------------------------------------------------------------------------
package t_ff_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int unsigned MAX_W = 32;

   typedef logic [MAX_W-1:0] word_t;

   // Parallel-load target: anything above the modulus is pinned to MAX_VAL.
   function automatic word_t clamp_val(input word_t d, input word_t max_val);
      word_t r;
      if (d > max_val) begin
         r = max_val;
      end else begin
         r = d;
      end
      return r;
   endfunction

   // Toggle vector for an enabled count step.
   // Away from the boundary this is the classic ripple rule: bit i toggles when
   // all lower bits are 1 (up) or all lower bits are 0 (down). At the boundary
   // the vector either jumps to the opposite end (T = Q or T = MAX_VAL) or,
   // when saturating, is zero so the counter holds.
   // Out-of-range Q (> max_val) is not special-cased: it simply keeps rippling,
   // which rolls over naturally going up and re-enters the range going down.
   function automatic word_t toggle_vec(input word_t q,
                                        input logic  up,
                                        input word_t max_val,
                                        input logic  sat);
      word_t t;
      logic  run;
      t   = '0;
      run = 1'b1;
      if (up == DIR_UP) begin
         if (q == max_val) begin
            if (sat) begin
               t = '0;
            end else begin
               t = q;
            end
         end else begin
            for (int i = 0; i < MAX_W; i++) begin
               t[i] = run;
               run  = run & q[i];
            end
         end
      end else begin
         if (q == '0) begin
            if (sat) begin
               t = '0;
            end else begin
               t = max_val;
            end
         end else begin
            for (int i = 0; i < MAX_W; i++) begin
               t[i] = run;
               run  = run & ~q[i];
            end
         end
      end
      return t;
   endfunction

endpackage

// File: rtl/t_ff_cell.sv
// -----------------------------------------------------------------------------
// t_ff_cell
// Single T flip-flop: Q toggles on each rising clk edge where T is 1.
// Storage only; all toggle decisions are made by the enclosing counter.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-high reset, forces Q=0
//   T     in  toggle enable
//   Q     out stored bit
//   Q_not out complement of Q
// -----------------------------------------------------------------------------
module t_ff_cell (
   input  logic clk,
   input  logic rst,
   input  logic T,
   output logic Q,
   output logic Q_not
);

   logic q_q;

   // Storage bit: next state is always Q XOR T.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_q ^ T;
      end
   end

   assign Q     = q_q;
   assign Q_not = ~q_q;

endmodule

// File: rtl/t_ff_counter.sv
// -----------------------------------------------------------------------------
// t_ff_counter
// Up/down modulo counter (0..MAX_VAL) built from WIDTH T flip-flop cells.
// The top computes the toggle vector; the cells only store bits.
//
// Parameters:
//   WIDTH   counter width, 1..32
//   MAX_VAL highest count value, 1..2**WIDTH-1
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset (Q=0, wrap=0)
//   en    in   count enable
//   up    in   direction, 1 = increment, 0 = decrement
//   load  in   synchronous parallel load (highest priority)
//   d     in   load value, clamped to MAX_VAL
//   Q     out  registered count
//   Q_not out  ~Q
//   tc    out  terminal count, combinational: en & (up ? Q==MAX_VAL : Q==0)
//   wrap  out  registered pulse, high the cycle after a wrap event
//
// Build option:
//   T_CNT_SAT_EN  when defined the counter saturates at the boundary instead
//                 of wrapping, and wrap stays 0.
// -----------------------------------------------------------------------------
module t_ff_counter
   import t_ff_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_not,
   output logic             tc,
   output logic             wrap
);

`ifdef T_CNT_SAT_EN
   localparam logic SAT_MODE = 1'b1;
`else
   localparam logic SAT_MODE = 1'b0;
`endif

   localparam word_t MAX_EXT = word_t'(MAX_VAL);

   logic [WIDTH-1:0] q_s;
   logic [WIDTH-1:0] q_not_s;
   logic [WIDTH-1:0] t_d;
   word_t            q_ext_s;
   word_t            clamp_full_s;
   word_t            tog_full_s;
   logic             at_top_s;
   logic             at_bot_s;
   logic             wrap_d;
   logic             wrap_q;
   logic             unused_hi_s;

   assign q_ext_s      = word_t'(q_s);
   assign clamp_full_s = clamp_val(word_t'(d), MAX_EXT);
   assign tog_full_s   = toggle_vec(q_ext_s, up, MAX_EXT, SAT_MODE);
   // Only the low WIDTH bits of the 32-bit helper results are meaningful.
   assign unused_hi_s  = ^{clamp_full_s, tog_full_s};

   assign at_top_s = (q_s == MAX_VAL);
   assign at_bot_s = (q_s == {WIDTH{1'b0}});

   // Toggle vector: load > count > hold. A load toggles exactly the bits
   // where Q differs from the clamped load value.
   always_comb begin
      t_d = {WIDTH{1'b0}};
      if (load) begin
         t_d = q_s ^ clamp_full_s[WIDTH-1:0];
      end else if (en) begin
         t_d = tog_full_s[WIDTH-1:0];
      end else begin
         t_d = {WIDTH{1'b0}};
      end
   end

   // Wrap event detection for the next-cycle pulse; never fires when saturating.
   always_comb begin
      wrap_d = 1'b0;
      if (load) begin
         wrap_d = 1'b0;
      end else if (en) begin
         if (up == DIR_UP) begin
            wrap_d = at_top_s & ~SAT_MODE;
         end else begin
            wrap_d = at_bot_s & ~SAT_MODE;
         end
      end else begin
         wrap_d = 1'b0;
      end
   end

   // Wrap pulse register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      t_ff_cell u_cell (
         .clk   (clk),
         .rst   (rst),
         .T     (t_d[i]),
         .Q     (q_s[i]),
         .Q_not (q_not_s[i])
      );
   end

   assign Q     = q_s;
   assign Q_not = q_not_s;
   assign tc    = en & ((up == DIR_UP) ? at_top_s : at_bot_s);
   assign wrap  = wrap_q;

endmodule
